// File: rtl/emu_trace_pkg.sv
// Shared types and defaults for the stepped-emulation trace capture block.
// Holds the sequencer state encoding and the buffer occupancy width helper.
package emu_trace_pkg;

  localparam int DEF_WIDTH  = 25;
  localparam int DEF_DEPTH  = 256;
  localparam int DEF_SETTLE = 2;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  // One extra bit so a completely full buffer is distinguishable from empty.
  function automatic int occWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through sample buffer between the stepping sequencer and
// the host drain stream; head word is always visible on rdata_o.
module trace_fifo
  import emu_trace_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            wdata_i,
  output logic                        full_o,
  input  logic                        pop_i,
  output logic                        valid_o,
  output logic [WIDTH-1:0]            rdata_o,
  output logic [occWidth(DEPTH)-1:0]  count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = occWidth(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             doPush, doPop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign valid_o = (count_q != '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && valid_o;
  assign rdata_o = mem_q[rdPtr_q];
  assign count_o = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + PW'(1);
    if (doPop)  rdPtr_d = rdPtr_q + PW'(1);
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/emu_trace_capture.sv
// Host-side stepping sequencer: pulses the stepped clock generator, waits for
// the model to settle, then records (decimated) output samples into a buffer.
module emu_trace_capture
  import emu_trace_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int SETTLE = DEF_SETTLE,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic [CNT_W-1:0]            num_steps_i,
  input  logic [7:0]                  decim_i,
  input  logic                        abort_i,
  input  logic [WIDTH-1:0]            v_out_i,
  output logic                        step_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        rd_valid_o,
  input  logic                        rd_ready_i,
  output logic [WIDTH-1:0]            rd_data_o,
  output logic [occWidth(DEPTH)-1:0]  count_o
);

  localparam int SW = $clog2(SETTLE + 1);

  state_e           state_q;
  logic             step_q, busy_q, done_q;
  logic [CNT_W-1:0] numSteps_q, stepCnt_q;
  logic [7:0]       decim_q, decimCnt_q;
  logic [SW-1:0]    settleCnt_q;

  logic capture, lastStep, fifoFull, samplePush;

  assign capture    = (decimCnt_q == (decim_q - 8'd1));
  assign lastStep   = ((stepCnt_q + CNT_W'(1)) == numSteps_q);
  assign samplePush = (state_q == S_SAMPLE) && capture && !fifoFull && !abort_i;

  assign step_o = step_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

  // Outputs are registered alongside the state so step_o/done_o/busy_o are
  // glitch-free; abort wins over every other event in a running sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      step_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      numSteps_q  <= '0;
      stepCnt_q   <= '0;
      decim_q     <= '0;
      decimCnt_q  <= '0;
      settleCnt_q <= '0;
    end else begin
      step_q <= 1'b0;
      done_q <= 1'b0;
      if (abort_i && (state_q != S_IDLE)) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i) begin
              numSteps_q <= num_steps_i;
              decim_q    <= (decim_i == 8'd0) ? 8'd1 : decim_i;
              stepCnt_q  <= '0;
              decimCnt_q <= '0;
              if (num_steps_i == '0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                state_q <= S_STEP;
                step_q  <= 1'b1;
                busy_q  <= 1'b1;
              end
            end
          end
          S_STEP: begin
            settleCnt_q <= SW'(SETTLE);
            state_q     <= S_SETTLE;
          end
          S_SETTLE: begin
            if (settleCnt_q == SW'(1)) state_q <= S_SAMPLE;
            else                       settleCnt_q <= settleCnt_q - SW'(1);
          end
          S_SAMPLE: begin
            // A capture into a full buffer holds here so no sample is lost.
            if (!(capture && fifoFull)) begin
              decimCnt_q <= capture ? 8'd0 : (decimCnt_q + 8'd1);
              stepCnt_q  <= stepCnt_q + CNT_W'(1);
              if (lastStep) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                state_q <= S_STEP;
                step_q  <= 1'b1;
              end
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  trace_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (samplePush),
    .wdata_i (v_out_i),
    .full_o  (fifoFull),
    .pop_i   (rd_ready_i),
    .valid_o (rd_valid_o),
    .rdata_o (rd_data_o),
    .count_o (count_o)
  );

endmodule

// File: tb/tb_emu_trace_capture.sv
// Self-checking bench for emu_trace_capture: table-driven runs, hand-written
// corner sequences and randomized runs against a trace-level reference model.
module tb_emu_trace_capture;

  localparam int WIDTH  = 25;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 2;
  localparam int CNT_W  = 16;
  localparam int PERIOD = SETTLE + 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start_i;
  logic [CNT_W-1:0]   num_steps_i;
  logic [7:0]         decim_i;
  logic               abort_i;
  logic [WIDTH-1:0]   v_out_i;
  logic               step_o, busy_o, done_o, rd_valid_o, rd_ready_i;
  logic [WIDTH-1:0]   rd_data_o;
  logic [$clog2(DEPTH):0] count_o;

  emu_trace_capture #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .SETTLE(SETTLE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .num_steps_i(num_steps_i),
    .decim_i(decim_i), .abort_i(abort_i), .v_out_i(v_out_i), .step_o(step_o),
    .busy_o(busy_o), .done_o(done_o), .rd_valid_o(rd_valid_o),
    .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Trace-level observation of the run: step pulses, the value presented to
  // the model at each step, done pulses and every word popped by the host.
  int               cyc = 0;
  int               stepsSeen = 0;
  int               doneCount = 0;
  int               doneCyc = -1;
  int               startCyc = 0;
  int               valMode = 0;
  logic [WIDTH-1:0] curVal = '0;
  logic [WIDTH-1:0] newVal;
  logic [WIDTH-1:0] stepVals[$];
  logic [WIDTH-1:0] popped[$];
  logic [WIDTH-1:0] expWords[$];
  int               stepTimes[$];

  assign v_out_i = curVal;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (step_o) begin
      newVal = (valMode == 0) ? WIDTH'(stepsSeen * 100) : WIDTH'($urandom);
      curVal = newVal;
      stepVals.push_back(newVal);
      stepTimes.push_back(cyc);
      stepsSeen = stepsSeen + 1;
    end
    if (done_o) begin
      doneCount = doneCount + 1;
      doneCyc   = cyc;
    end
    if (rd_valid_o && rd_ready_i) popped.push_back(rd_data_o);
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got hang expected finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clearRun();
    stepVals.delete();
    popped.delete();
    stepTimes.delete();
    stepsSeen = 0;
    doneCount = 0;
    doneCyc   = -1;
  endtask

  // Called one time unit after a rising edge; start is accepted at the next edge.
  task automatic applyStimulus(input int n, input int d);
    start_i     = 1'b1;
    num_steps_i = CNT_W'(n);
    decim_i     = 8'(d);
    @(posedge clk);
    startCyc = cyc;
    #1;
    start_i = 1'b0;
  endtask

  // Reference model: a step k is captured when (k+1) is a multiple of decim.
  task automatic buildExpected(input int d, input int maxSteps);
    int eff;
    eff = (d == 0) ? 1 : d;
    expWords.delete();
    for (int k = 0; k < stepVals.size() && k < maxSteps; k++)
      if (((k + 1) % eff) == 0) expWords.push_back(stepVals[k]);
  endtask

  task automatic waitDone(input int budget, input bit randomReady);
    for (int i = 0; i < budget && doneCount == 0; i++) begin
      if (randomReady) rd_ready_i = 1'($urandom_range(0, 1));
      waitCycles(1);
    end
    checkOutput("done pulse count", doneCount, 1);
  endtask

  task automatic drain(input int budget);
    rd_ready_i = 1'b1;
    for (int i = 0; i < budget && count_o != 0; i++) waitCycles(1);
    rd_ready_i = 1'b0;
    waitCycles(1);
    checkOutput("drained occupancy", count_o, 0);
  endtask

  task automatic compareWords(input string name);
    checkOutput({name, " word count"}, popped.size(), expWords.size());
    for (int i = 0; i < popped.size() && i < expWords.size(); i++)
      checkOutput({name, " word"}, longint'(popped[i]), longint'(expWords[i]));
  endtask

  typedef struct {
    int numSteps;
    int decim;
    bit ready;
    int expSteps;
    int expWords;
    int expDoneOfs;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{numSteps: 4,  decim: 1, ready: 1'b0, expSteps: 4,  expWords: 4, expDoneOfs: 17};
    vecs[1] = '{numSteps: 10, decim: 3, ready: 1'b1, expSteps: 10, expWords: 3, expDoneOfs: 41};
    vecs[2] = '{numSteps: 5,  decim: 0, ready: 1'b1, expSteps: 5,  expWords: 5, expDoneOfs: 21};
    vecs[3] = '{numSteps: 0,  decim: 5, ready: 1'b1, expSteps: 0,  expWords: 0, expDoneOfs: 1};
    vecs[4] = '{numSteps: 3,  decim: 2, ready: 1'b1, expSteps: 3,  expWords: 1, expDoneOfs: 13};
    vecs[5] = '{numSteps: 4,  decim: 1, ready: 1'b1, expSteps: 4,  expWords: 4, expDoneOfs: 17};

    rst_n = 1'b0; start_i = 1'b0; num_steps_i = '0; decim_i = '0;
    abort_i = 1'b0; rd_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset step_o", step_o, 0);
    checkOutput("reset busy_o", busy_o, 0);
    checkOutput("reset done_o", done_o, 0);
    checkOutput("reset rd_valid_o", rd_valid_o, 0);
    checkOutput("reset count_o", count_o, 0);
    rst_n = 1'b1;
    waitCycles(2);

    $display("[TB] table-driven runs");
    for (int v = 0; v < 6; v++) begin
      clearRun();
      valMode    = 0;
      rd_ready_i = vecs[v].ready;
      applyStimulus(vecs[v].numSteps, vecs[v].decim);
      waitDone(300, 1'b0);
      checkOutput("done cycle", doneCyc - startCyc, vecs[v].expDoneOfs);
      checkOutput("step pulses", stepsSeen, vecs[v].expSteps);
      for (int k = 0; k < stepTimes.size(); k++)
        checkOutput("step spacing", stepTimes[k] - startCyc, 1 + PERIOD * k);
      checkOutput("busy after done", busy_o, 0);
      drain(50);
      buildExpected(vecs[v].decim, vecs[v].numSteps);
      checkOutput("model word count", expWords.size(), vecs[v].expWords);
      compareWords("table");
    end

    $display("[TB] first sample latency");
    clearRun();
    applyStimulus(1, 1);
    waitCycles(3);
    @(negedge clk);
    checkOutput("rd_valid before write", rd_valid_o, 0);
    @(negedge clk);
    checkOutput("rd_valid after write", rd_valid_o, 1);
    waitDone(20, 1'b0);
    drain(20);

    // With the buffer full the fifth step is still issued; its sample holds.
    $display("[TB] backpressure");
    clearRun();
    applyStimulus(8, 1);
    waitCycles(60);
    checkOutput("stall steps", stepsSeen, 5);
    checkOutput("stall busy", busy_o, 1);
    checkOutput("stall occupancy", count_o, DEPTH);
    checkOutput("stall no done", doneCount, 0);
    rd_ready_i = 1'b1;
    waitDone(100, 1'b0);
    checkOutput("backpressure steps", stepsSeen, 8);
    drain(20);
    buildExpected(1, 8);
    compareWords("backpressure");

    $display("[TB] start while busy / start during done");
    clearRun();
    rd_ready_i = 1'b1;
    applyStimulus(6, 1);
    waitCycles(6);
    start_i = 1'b1; num_steps_i = CNT_W'(2);
    @(posedge clk); #1; start_i = 1'b0;
    waitDone(100, 1'b0);
    checkOutput("busy-start steps", stepsSeen, 6);
    checkOutput("busy-start done cycle", doneCyc - startCyc, 1 + PERIOD * 6);
    drain(20);
    clearRun();
    applyStimulus(1, 1);
    waitCycles(4);
    start_i = 1'b1; num_steps_i = CNT_W'(3);
    @(posedge clk); #1; start_i = 1'b0;
    waitCycles(20);
    checkOutput("done-start steps", stepsSeen, 1);
    checkOutput("done-start dones", doneCount, 1);
    checkOutput("done-start busy", busy_o, 0);
    drain(20);

    $display("[TB] abort");
    clearRun();
    rd_ready_i = 1'b0;
    applyStimulus(10, 1);
    waitCycles(9);
    abort_i = 1'b1;
    @(posedge clk); #1; abort_i = 1'b0;
    @(negedge clk);
    checkOutput("abort busy", busy_o, 0);
    checkOutput("abort step", step_o, 0);
    waitCycles(20);
    checkOutput("abort steps", stepsSeen, 3);
    checkOutput("abort no done", doneCount, 0);
    checkOutput("abort occupancy", count_o, 2);
    drain(20);
    buildExpected(1, 2);
    compareWords("abort");

    $display("[TB] async reset mid-run");
    clearRun();
    applyStimulus(10, 1);
    waitCycles(12);
    checkOutput("pre-reset step", step_o, 1);
    checkOutput("pre-reset occupancy", count_o, 3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async step", step_o, 0);
    checkOutput("async busy", busy_o, 0);
    checkOutput("async rd_valid", rd_valid_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    waitCycles(2);
    checkOutput("post-reset occupancy", count_o, 0);

    $display("[TB] randomized runs");
    valMode = 1;
    for (int r = 0; r < 10; r++) begin
      int n, d;
      n = $urandom_range(1, 12);
      d = $urandom_range(0, 4);
      clearRun();
      applyStimulus(n, d);
      waitDone(2000, 1'b1);
      checkOutput("random steps", stepsSeen, n);
      drain(50);
      buildExpected(d, n);
      compareWords("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
